board_state: RTL and testbench

- Game-board keeper for the elimination tic-tac-toe datapath. Consumes the move stream (location, mark) from the keypad/turn controller and produces the registered board matrix a0..a8 and the gameend flag that the controller reads back.
- Each player holds at most MAX_MARKS marks. A placement beyond that limit evicts that player's oldest mark in the same cycle.
- Detects three-in-a-row on the post-elimination board and latches the winner.

---
 rtl/board_state_pkg.sv | 39 +++
 rtl/board_state_fifo.sv | 50 +++++
 rtl/board_state.sv | 126 ++++++++++++
 tb/tb_board_state.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_state_pkg.sv
// Shared definitions for the board keeper.
// Exports cell and game-status encodings, the board vector type,
// the eight winning lines, and a helper that reports who owns a line.
package board_pkg;

    localparam logic [1:0] MARK_NONE = 2'b00;
    localparam logic [1:0] MARK_X    = 2'b10;
    localparam logic [1:0] MARK_O    = 2'b01;

    localparam logic [1:0] GAME_PLAY = 2'b00;
    localparam logic [1:0] GAME_XWIN = 2'b10;
    localparam logic [1:0] GAME_OWIN = 2'b01;

    // Nine cells of two bits each; cell i lives in board[i].
    typedef logic [8:0][1:0] board_t;

    localparam logic [3:0] WIN_LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // Mark filling all three cells of the line, or MARK_NONE.
    function automatic logic [1:0] line_owner(input board_t b, input logic [2:0] line);
        logic [1:0] c0, c1, c2;
        c0 = b[WIN_LINES[line][0]];
        c1 = b[WIN_LINES[line][1]];
        c2 = b[WIN_LINES[line][2]];
        if (c0 != MARK_NONE && c0 == c1 && c1 == c2)
            return c0;
        return MARK_NONE;
    endfunction

endpackage

// File: rtl/board_state_fifo.sv
// mark_fifo: per-player circular FIFO of board locations, oldest first.
// Ports: clk, rst (async, active-high), push/din write a location,
// pop drops the oldest, dout shows the oldest, count = occupancy, full.
// A simultaneous push and pop keeps the occupancy unchanged.
module mark_fifo #(
    parameter int unsigned DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [3:0] din,
    output logic [3:0] dout,
    output logic [2:0] count,
    output logic       full
);
    import board_pkg::*;

    localparam logic [1:0] LAST    = 2'(DEPTH - 1);
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    logic [3:0] mem [DEPTH];
    logic [1:0] rd_ptr, wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == LAST) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == LAST) ? 2'd0 : rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rd_ptr];
    assign full = (count == DEPTH_C);

endmodule

// File: rtl/board_state.sv
// board_state: elimination tic-tac-toe board keeper.
// Inputs: clk, rst (async, active-high), location (cell 0..8), mark
// (10 = X, 01 = O, 00 = none), both held between moves.
// Outputs: a0..a8 registered cells, gameend (00 play, 10 X, 01 O, sticky),
// countX/countO marks currently on the board per player.
// A move is a change of the held {mark, location} pair with mark != 00.
// Placing beyond MAX_MARKS evicts that player's oldest mark on the same edge.
module board_state #(
    parameter int unsigned MAX_MARKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] location,
    input  logic [1:0] mark,
    output logic [1:0] a0,
    output logic [1:0] a1,
    output logic [1:0] a2,
    output logic [1:0] a3,
    output logic [1:0] a4,
    output logic [1:0] a5,
    output logic [1:0] a6,
    output logic [1:0] a7,
    output logic [1:0] a8,
    output logic [1:0] gameend,
    output logic [2:0] countX,
    output logic [2:0] countO
);
    import board_pkg::*;

    board_t     board, next_board;
    logic [5:0] prev_pair;
    logic [1:0] next_gameend;
    logic       move_req, loc_ok, target_empty, accept;
    logic       is_x, is_o, push_x, push_o, full_x, full_o, evict;
    logic [3:0] old_x, old_o, old_loc;
    logic       xwin, owin;

    assign is_x     = (mark == MARK_X);
    assign is_o     = (mark == MARK_O);
    assign loc_ok   = (location <= 4'd8);
    assign move_req = (mark != MARK_NONE) && ({mark, location} != prev_pair);

    always_comb begin
        target_empty = 1'b0;
        for (int unsigned i = 0; i < 9; i++)
            if (location == 4'(i))
                target_empty = (board[4'(i)] == MARK_NONE);
    end

    assign accept  = move_req && (gameend == GAME_PLAY) && loc_ok &&
                     target_empty && (is_x || is_o);
    assign push_x  = accept && is_x;
    assign push_o  = accept && is_o;
    assign evict   = (push_x && full_x) || (push_o && full_o);
    assign old_loc = is_x ? old_x : old_o;

    mark_fifo #(.DEPTH(MAX_MARKS)) u_fifo_x (
        .clk   (clk),
        .rst   (rst),
        .push  (push_x),
        .pop   (push_x && full_x),
        .din   (location),
        .dout  (old_x),
        .count (countX),
        .full  (full_x)
    );

    mark_fifo #(.DEPTH(MAX_MARKS)) u_fifo_o (
        .clk   (clk),
        .rst   (rst),
        .push  (push_o),
        .pop   (push_o && full_o),
        .din   (location),
        .dout  (old_o),
        .count (countO),
        .full  (full_o)
    );

    // Eviction and placement are applied before the win check so that a
    // line broken by eviction never reports a win.
    always_comb begin
        next_board = board;
        for (int unsigned i = 0; i < 9; i++) begin
            if (evict && old_loc == 4'(i))
                next_board[4'(i)] = MARK_NONE;
            if (accept && location == 4'(i))
                next_board[4'(i)] = mark;
        end
    end

    always_comb begin
        xwin = 1'b0;
        owin = 1'b0;
        for (int unsigned l = 0; l < 8; l++) begin
            if (line_owner(next_board, 3'(l)) == MARK_X) xwin = 1'b1;
            if (line_owner(next_board, 3'(l)) == MARK_O) owin = 1'b1;
        end
        next_gameend = GAME_PLAY;
        if (xwin)      next_gameend = GAME_XWIN;
        else if (owin) next_gameend = GAME_OWIN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            board     <= '0;
            gameend   <= GAME_PLAY;
            prev_pair <= '0;
        end else begin
            prev_pair <= {mark, location};
            board     <= next_board;
            if (accept)
                gameend <= next_gameend;
        end
    end

    assign a0 = board[0];
    assign a1 = board[1];
    assign a2 = board[2];
    assign a3 = board[3];
    assign a4 = board[4];
    assign a5 = board[5];
    assign a6 = board[6];
    assign a7 = board[7];
    assign a8 = board[8];

endmodule

// File: tb/tb_board_state.sv
module tb_board_state;

    localparam int MAXM = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] location = 4'd0;
    logic [1:0] mark = 2'b00;
    logic [1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
    logic [1:0] gameend;
    logic [2:0] countX, countO;

    board_state #(.MAX_MARKS(MAXM)) dut (
        .clk(clk), .rst(rst), .location(location), .mark(mark),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6),
        .a7(a7), .a8(a8), .gameend(gameend), .countX(countX), .countO(countO)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [17:0] dut_board;
    assign dut_board = {a8, a7, a6, a5, a4, a3, a2, a1, a0};

    // Reference model: cells, per-player age queues, winner, last sampled pair.
    logic [1:0] m_cell [9];
    int         m_qx [$];
    int         m_qo [$];
    logic [1:0] m_end;
    logic [5:0] m_prev;
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic logic [17:0] exp_board();
        logic [17:0] v;
        for (int i = 0; i < 9; i++) v[2*i +: 2] = m_cell[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_cell[i] = 2'b00;
        m_qx.delete();
        m_qo.delete();
        m_end  = 2'b00;
        m_prev = 6'd0;
    endtask

    task automatic model_step(input logic [1:0] mk, input logic [3:0] lc);
        bit req;
        req = (mk != 2'b00) && ({mk, lc} != m_prev);
        m_prev = {mk, lc};
        if (req && m_end == 2'b00 && lc <= 8 && (mk == 2'b10 || mk == 2'b01)
            && m_cell[lc] == 2'b00) begin
            if (mk == 2'b10) begin
                if (m_qx.size() == MAXM) m_cell[m_qx.pop_front()] = 2'b00;
                m_qx.push_back(int'(lc));
            end else begin
                if (m_qo.size() == MAXM) m_cell[m_qo.pop_front()] = 2'b00;
                m_qo.push_back(int'(lc));
            end
            m_cell[lc] = mk;
            for (int l = 0; l < 8; l++)
                if (m_cell[lines[l][0]] == mk && m_cell[lines[l][1]] == mk &&
                    m_cell[lines[l][2]] == mk)
                    m_end = mk;
        end
    endtask

    // Drive a pair on the falling edge, advance the model at the rising edge,
    // leave time 1 unit after the edge for sampling.
    task automatic apply(input logic [1:0] mk, input logic [3:0] lc);
        @(negedge clk);
        mark = mk;
        location = lc;
        @(posedge clk);
        model_step(mk, lc);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mark = 2'b00;
        location = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if ({dut_board, gameend, countX, countO} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_state: got board=%h end=%b cx=%0d co=%0d, want all zero",
                     dut_board, gameend, countX, countO);
        end
    endtask

    task automatic test_basic();
        do_reset();
        apply(2'b10, 4'd4);
        apply(2'b01, 4'd0);
        apply(2'b10, 4'd8);
        n_cmp++;
        if (a4 !== 2'b10 || a0 !== 2'b01 || a8 !== 2'b10 || countX !== 3'd2 ||
            countO !== 3'd1 || gameend !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_place: got a4=%b a0=%b a8=%b cx=%0d co=%0d end=%b, want 10 01 10 2 1 00",
                     a4, a0, a8, countX, countO, gameend);
        end
        n_cmp++;
        if (dut_board !== exp_board()) begin
            n_fail++;
            $display("FAIL basic_board: got %h want %h", dut_board, exp_board());
        end
    endtask

    task automatic test_evict();
        do_reset();
        apply(2'b10, 4'd0);
        apply(2'b01, 4'd2);
        apply(2'b10, 4'd1);
        apply(2'b01, 4'd7);
        apply(2'b10, 4'd5);
        apply(2'b10, 4'd6);
        n_cmp++;
        if (a0 !== 2'b00 || a6 !== 2'b10 || countX !== 3'd3 || gameend !== 2'b00) begin
            n_fail++;
            $display("FAIL evict_oldest: got a0=%b a6=%b cx=%0d end=%b, want 00 10 3 00",
                     a0, a6, countX, gameend);
        end
        n_cmp++;
        if (dut_board !== exp_board() || countO !== 3'(m_qo.size())) begin
            n_fail++;
            $display("FAIL evict_board: got %h co=%0d want %h co=%0d",
                     dut_board, countO, exp_board(), m_qo.size());
        end
    endtask

    task automatic test_win();
        do_reset();
        apply(2'b10, 4'd0);
        apply(2'b10, 4'd1);
        apply(2'b10, 4'd2);
        n_cmp++;
        if (gameend !== 2'b10) begin
            n_fail++;
            $display("FAIL win_x: got gameend=%b want 10", gameend);
        end
        apply(2'b01, 4'd5);
        apply(2'b01, 4'd5);
        n_cmp++;
        if (a5 !== 2'b00 || gameend !== 2'b10 || countO !== 3'd0) begin
            n_fail++;
            $display("FAIL win_frozen: got a5=%b end=%b co=%0d want 00 10 0", a5, gameend, countO);
        end
    endtask

    task automatic test_evict_break();
        do_reset();
        apply(2'b10, 4'd3);
        apply(2'b10, 4'd4);
        apply(2'b10, 4'd8);
        apply(2'b10, 4'd5);
        n_cmp++;
        if (gameend !== 2'b00 || a3 !== 2'b00 || a5 !== 2'b10 || countX !== 3'd3) begin
            n_fail++;
            $display("FAIL evict_break: got end=%b a3=%b a5=%b cx=%0d want 00 00 10 3",
                     gameend, a3, a5, countX);
        end
    endtask

    task automatic test_hold();
        do_reset();
        for (int i = 0; i < 50; i++) apply(2'b10, 4'd4);
        n_cmp++;
        if (countX !== 3'd1 || a4 !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_single: got cx=%0d a4=%b want 1 10", countX, a4);
        end
        apply(2'b00, 4'd4);
        apply(2'b10, 4'd4);
        n_cmp++;
        if (countX !== 3'd1 || dut_board !== exp_board()) begin
            n_fail++;
            $display("FAIL hold_occupied: got cx=%0d board=%h want 1 %h", countX, dut_board, exp_board());
        end
        apply(2'b10, 4'd1);
        apply(2'b10, 4'd6);
        apply(2'b10, 4'd2);
        apply(2'b00, 4'd2);
        apply(2'b10, 4'd4);
        n_cmp++;
        if (a4 !== 2'b10 || a1 !== 2'b00 || countX !== 3'd3 || gameend !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_reuse: got a4=%b a1=%b cx=%0d end=%b want 10 00 3 10",
                     a4, a1, countX, gameend);
        end
    endtask

    task automatic test_bad_loc();
        do_reset();
        apply(2'b10, 4'd9);
        apply(2'b10, 4'd15);
        n_cmp++;
        if (dut_board !== 18'd0 || countX !== 3'd0) begin
            n_fail++;
            $display("FAIL bad_location: got board=%h cx=%0d want 0 0", dut_board, countX);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        apply(2'b10, 4'd0);
        apply(2'b01, 4'd4);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({dut_board, gameend, countX, countO} !== 26'd0) begin
            n_fail++;
            $display("FAIL async_reset: got board=%h end=%b cx=%0d co=%0d want zero",
                     dut_board, gameend, countX, countO);
        end
        mark = 2'b00;
        location = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        apply(2'b10, 4'd0);
        n_cmp++;
        if (a0 !== 2'b10 || countX !== 3'd1) begin
            n_fail++;
            $display("FAIL first_after_reset: got a0=%b cx=%0d want 10 1", a0, countX);
        end
    endtask

    task automatic test_random();
        logic [1:0] mk;
        logic [3:0] lc;
        int         done_cycles;
        do_reset();
        mk = 2'b00;
        lc = 4'd0;
        done_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 2))
                    0:       mk = 2'b00;
                    1:       mk = 2'b10;
                    default: mk = 2'b01;
                endcase
                lc = 4'($urandom_range(0, 10));
            end
            apply(mk, lc);
            n_cmp++;
            if (dut_board !== exp_board() || gameend !== m_end ||
                countX !== 3'(m_qx.size()) || countO !== 3'(m_qo.size())) begin
                n_fail++;
                $display("FAIL random_%0d: got board=%h end=%b cx=%0d co=%0d want %h %b %0d %0d",
                         i, dut_board, gameend, countX, countO,
                         exp_board(), m_end, m_qx.size(), m_qo.size());
            end
            if (m_end != 2'b00) done_cycles++;
            if (done_cycles > 3) begin
                do_reset();
                mk = 2'b00;
                lc = 4'd0;
                done_cycles = 0;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_evict();
        test_win();
        test_evict_break();
        test_hold();
        test_bad_loc();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
